// File: rtl/sha256_state_acc_if.sv
// Block-result handshake between a SHA-256 compression core and the state accumulator.
// The producer drives valid/data/last; the accumulator returns ready.
interface sha256_state_acc_if #(
    parameter int NUM_WORDS = 8,
    parameter int WORD_W    = 32
);
    logic                        acc_valid;
    logic                        acc_ready;
    logic                        acc_last;
    logic [NUM_WORDS*WORD_W-1:0] acc_data;

    modport master (
        output acc_valid,
        output acc_data,
        output acc_last,
        input  acc_ready
    );

    modport slave (
        input  acc_valid,
        input  acc_data,
        input  acc_last,
        output acc_ready
    );
endinterface

// File: rtl/sha256_state_acc.sv
// SHA-2 chaining-state accumulator: H += compression output, one word per cycle.
// Latency NUM_WORDS cycles per block; acc_ready only in WAIT, so the producer stalls while a block is added.
module sha256_state_acc #(
    parameter int NUM_WORDS  = 8,
    parameter int WORD_W     = 32,
    parameter int MAX_BLOCKS = 2,
    parameter logic [NUM_WORDS*WORD_W-1:0] IV_A =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19,
    parameter logic [NUM_WORDS*WORD_W-1:0] IV_B =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                mode,
    sha256_state_acc_if.slave                   acc,
    output logic [NUM_WORDS*WORD_W-1:0]         state_out,
    output logic                                digest_valid,
    output logic [$clog2(MAX_BLOCKS+1)-1:0]     blk_cnt,
    output logic                                busy,
    output logic                                err
);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_W = $clog2(MAX_BLOCKS+1);

    // Ascending packed range puts word 0 in the MSBs, matching the bus packing.
    typedef logic [0:NUM_WORDS-1][WORD_W-1:0] words_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_d;
    words_t           h;
    words_t           blk_buf;
    logic [IDX_W-1:0] idx;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             err_q;
    logic             xfer;
    logic             stray;
    logic             last_word;
    logic             at_max;

    assign last_word = (idx == IDX_W'(NUM_WORDS-1));
    assign cnt_inc   = cnt_q + 1'b1;
    assign at_max    = (cnt_inc == CNT_W'(MAX_BLOCKS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d       = state;
        acc.acc_ready = 1'b0;
        busy          = 1'b0;
        digest_valid  = 1'b0;
        xfer          = 1'b0;
        stray         = 1'b0;
        case (state)
            IDLE: begin
                stray = acc.acc_valid;
            end
            WAIT: begin
                acc.acc_ready = 1'b1;
                xfer          = acc.acc_valid;
                if (acc.acc_valid) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (last_word) begin
                    // Running out of block budget without a final block ends the message in error.
                    state_d = (last_q || at_max) ? DONE : WAIT;
                end
            end
            DONE: begin
                digest_valid = 1'b1;
                stray        = acc.acc_valid;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A new message overrides everything, including a same-cycle transfer.
        if (start) begin
            state_d = WAIT;
            xfer    = 1'b0;
            stray   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h       <= IV_A;
            blk_buf <= '0;
            idx     <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (start) begin
            h      <= mode ? IV_B : IV_A;
            idx    <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (xfer) begin
                blk_buf <= acc.acc_data;
                last_q  <= acc.acc_last;
                idx     <= '0;
            end
            if (state == ADD) begin
                h[idx] <= h[idx] + blk_buf[idx];
                idx    <= last_word ? '0 : idx + 1'b1;
                if (last_word) begin
                    if (cnt_q != CNT_W'(MAX_BLOCKS)) begin
                        cnt_q <= cnt_inc;
                    end
                    if (!last_q && at_max) begin
                        err_q <= 1'b1;
                    end
                end
            end
            if (stray) begin
                err_q <= 1'b1;
            end
        end
    end

    assign state_out = h;
    assign blk_cnt   = cnt_q;
    assign err       = err_q;
endmodule

// File: tb/tb_sha256_state_acc.sv
// Directed bench for sha256_state_acc: default 8x32 build plus a 4x64 build.
// Expected chaining states come from a word-wise adder model queued per block.
module tb_sha256_state_acc;
    localparam int NW   = 8;
    localparam int W    = 32;
    localparam int MAXB = 2;
    localparam logic [255:0] IVA =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IVB =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, mode;
    logic [255:0] state_out;
    logic         digest_valid, busy, err;
    logic [1:0]   blk_cnt;

    logic         start2, mode2;
    logic [255:0] state_out2;
    logic         digest_valid2, busy2, err2;
    logic [1:0]   blk_cnt2;

    always #5 clk = ~clk;

    sha256_state_acc_if #(.NUM_WORDS(NW), .WORD_W(W)) acc_if ();
    sha256_state_acc_if #(.NUM_WORDS(4),  .WORD_W(64)) acc_if2 ();

    sha256_state_acc dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .acc(acc_if),
        .state_out(state_out), .digest_valid(digest_valid), .blk_cnt(blk_cnt),
        .busy(busy), .err(err)
    );

    sha256_state_acc #(.NUM_WORDS(4), .WORD_W(64)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .acc(acc_if2),
        .state_out(state_out2), .digest_valid(digest_valid2), .blk_cnt(blk_cnt2),
        .busy(busy2), .err(err2)
    );

    typedef struct {
        logic [255:0] h;
        int           cnt;
        bit           err;
        bit           done;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] m_h;
    int           m_cnt;
    bit           m_err;
    int           vectors    = 0;
    int           miscompares = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] add_words(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < NW; i++) begin
            r[(NW-i)*W-1 -: W] = a[(NW-i)*W-1 -: W] + b[(NW-i)*W-1 -: W];
        end
        return r;
    endfunction

    task automatic do_start(input bit md);
        start = 1'b1;
        mode  = md;
        step();
        start = 1'b0;
        m_h   = md ? IVB : IVA;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic send_block(input string tag, input logic [255:0] d, input bit last);
        exp_t         e;
        logic [255:0] pre;
        logic [255:0] part;
        int           n;
        bit           rdy_seen;
        chk({tag, "_ready_before"}, acc_if.acc_ready, 1);
        pre   = m_h;
        m_h   = add_words(m_h, d);
        m_cnt = m_cnt + 1;
        if (!last && m_cnt == MAXB) m_err = 1'b1;
        e.h    = m_h;
        e.cnt  = m_cnt;
        e.err  = m_err;
        e.done = last || (m_cnt == MAXB);
        sb.push_back(e);
        acc_if.acc_valid = 1'b1;
        acc_if.acc_data  = d;
        acc_if.acc_last  = last;
        step();
        acc_if.acc_valid = 1'b0;
        acc_if.acc_data  = ~d;
        acc_if.acc_last  = ~last;
        step();
        part = pre;
        part[255 -: 32] = m_h[255 -: 32];
        chk({tag, "_word0_only"}, state_out, part);
        n = 1;
        rdy_seen = 1'b0;
        while (busy && n < 20) begin
            if (acc_if.acc_ready) rdy_seen = 1'b1;
            step();
            n++;
        end
        chk({tag, "_ready_low_in_add"}, rdy_seen, 0);
        chk({tag, "_add_cycles"}, n, NW);
        e = sb.pop_front();
        chk({tag, "_h"}, state_out, e.h);
        chk({tag, "_blk_cnt"}, blk_cnt, e.cnt);
        chk({tag, "_err"}, err, e.err);
        chk({tag, "_digest_valid"}, digest_valid, e.done);
        chk({tag, "_ready_after"}, acc_if.acc_ready, !e.done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;
        logic [255:0] exp2;
        logic [63:0]  iv0;
        logic [63:0]  one64;

        rst_n = 1'b0;
        start = 1'b0; mode = 1'b0;
        start2 = 1'b0; mode2 = 1'b0;
        acc_if.acc_valid  = 1'b0; acc_if.acc_data  = '0; acc_if.acc_last  = 1'b0;
        acc_if2.acc_valid = 1'b0; acc_if2.acc_data = '0; acc_if2.acc_last = 1'b0;
        m_h = IVA; m_cnt = 0; m_err = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_state_out", state_out, IVA);
        chk("rst_blk_cnt", blk_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", acc_if.acc_ready, 0);
        chk("rst_digest_valid", digest_valid, 0);
        chk("rst_err", err, 0);
        chk("rst2_state_out", state_out2, IVA);
        rst_n = 1'b1;
        step();
        chk("idle_ready", acc_if.acc_ready, 0);

        // Start with SHA-256 IV
        do_start(1'b0);
        chk("start_iv_a", state_out, IVA);
        chk("start_ready", acc_if.acc_ready, 1);

        // Single final block, word 0 wraps to 1
        d = '0;
        d[255 -: 32] = 32'h95f6199a;
        send_block("single", d, 1'b1);
        chk("single_word0_wrap", state_out[255 -: 32], 32'h00000001);

        // Stray valid in DONE: ignored but flagged
        acc_if.acc_valid = 1'b1;
        acc_if.acc_data  = {8{32'hdeadbeef}};
        step();
        acc_if.acc_valid = 1'b0;
        chk("done_stray_err", err, 1);
        chk("done_stray_h", state_out, m_h);
        chk("done_stray_cnt", blk_cnt, 1);

        // Two blocks of all-ones words -> IV+2
        do_start(1'b0);
        d = {8{32'h00000001}};
        send_block("two_a", d, 1'b0);
        send_block("two_b", d, 1'b1);
        chk("two_iv_plus2_w7", state_out[31:0], 32'h5be0cd1b);

        // Block budget exhausted without last
        do_start(1'b0);
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send_block("max_a", d, 1'b0);
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send_block("max_b", d, 1'b0);
        acc_if.acc_valid = 1'b1;
        step();
        acc_if.acc_valid = 1'b0;
        chk("max_done_h_hold", state_out, m_h);
        chk("max_done_cnt", blk_cnt, 2);
        chk("max_done_err", err, 1);

        // start and acc_valid together in WAIT: start wins
        do_start(1'b0);
        start = 1'b1; mode = 1'b0;
        acc_if.acc_valid = 1'b1;
        acc_if.acc_data  = {8{32'h11111111}};
        acc_if.acc_last  = 1'b1;
        step();
        start = 1'b0;
        acc_if.acc_valid = 1'b0;
        chk("collide_ready", acc_if.acc_ready, 1);
        chk("collide_busy", busy, 0);
        step();
        chk("collide_not_captured", busy, 0);
        chk("collide_h", state_out, IVA);

        // start with mode=1 during the 4th ADD cycle aborts the block
        acc_if.acc_valid = 1'b1;
        acc_if.acc_data  = {8{32'h01010101}};
        acc_if.acc_last  = 1'b0;
        step();
        acc_if.acc_valid = 1'b0;
        step(); step(); step();
        chk("abort_busy_before", busy, 1);
        start = 1'b1; mode = 1'b1;
        step();
        start = 1'b0; mode = 1'b0;
        chk("abort_iv_b", state_out, IVB);
        chk("abort_blk_cnt", blk_cnt, 0);
        chk("abort_ready", acc_if.acc_ready, 1);
        chk("abort_busy", busy, 0);
        step();
        chk("abort_h_stable", state_out, IVB);

        // Asynchronous reset in the middle of ADD
        acc_if.acc_valid = 1'b1;
        acc_if.acc_data  = {8{32'h0f0f0f0f}};
        acc_if.acc_last  = 1'b1;
        step();
        acc_if.acc_valid = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state_out", state_out, IVA);
        chk("arst_busy", busy, 0);
        chk("arst_ready", acc_if.acc_ready, 0);
        chk("arst_digest_valid", digest_valid, 0);
        chk("arst_blk_cnt", blk_cnt, 0);
        chk("arst_err", err, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_stays_idle", acc_if.acc_ready, 0);
        acc_if.acc_valid = 1'b1;
        step();
        acc_if.acc_valid = 1'b0;
        chk("idle_stray_err", err, 1);
        chk("idle_stray_h", state_out, IVA);

        // 4x64 build: single wrapping block, 4-cycle add
        start2 = 1'b1; mode2 = 1'b0;
        step();
        start2 = 1'b0;
        chk("w64_ready", acc_if2.acc_ready, 1);
        d = IVA;
        iv0 = d[255 -: 64];
        one64 = 64'h1;
        d = '0;
        d[255 -: 64] = 64'h0 - iv0 + one64;
        acc_if2.acc_valid = 1'b1;
        acc_if2.acc_data  = d;
        acc_if2.acc_last  = 1'b1;
        step();
        acc_if2.acc_valid = 1'b0;
        acc_if2.acc_data  = '1;
        step();
        chk("w64_word0_wrap", state_out2[255 -: 64], one64);
        step(); step();
        chk("w64_dv_low_e3", digest_valid2, 0);
        chk("w64_busy_e3", busy2, 1);
        step();
        exp2 = IVA;
        exp2[255 -: 64] = one64;
        chk("w64_dv_high_e4", digest_valid2, 1);
        chk("w64_blk_cnt", blk_cnt2, 1);
        chk("w64_h", state_out2, exp2);
        chk("w64_err", err2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
